// File: rtl/divider.sv
// Multi-cycle restoring divider for DIV/DIVU: quotient on lo_out, remainder on hi_out.
// One shift-subtract step per cycle on magnitudes; the sign is fixed up on the last step.
module divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
    logic             qneg_q, rneg_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_d, quo_d, q_fix, r_fix;

    always_comb begin
        a_neg   = is_signed & dividend[WIDTH-1];
        b_neg   = is_signed & divisor[WIDTH-1];
        a_mag   = a_neg ? (~dividend + WIDTH'(1)) : dividend;
        b_mag   = b_neg ? (~divisor + WIDTH'(1)) : divisor;
        // Partial remainder stays below the divisor, so one compare decides the quotient bit.
        shifted = {rem_q, quo_q[WIDTH-1]};
        if (shifted >= {1'b0, dsr_q}) begin
            rem_d = WIDTH'(shifted - {1'b0, dsr_q});
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        q_fix = qneg_q ? (~quo_d + WIDTH'(1)) : quo_d;
        r_fix = rneg_q ? (~rem_d + WIDTH'(1)) : rem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        if (divisor == '0) begin
                            hi_q    <= '0;
                            lo_q    <= '0;
                            state_q <= DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= a_mag;
                            dsr_q   <= b_mag;
                            qneg_q  <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                            cnt_q   <= '0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            lo_q    <= q_fix;
                            hi_q    <= r_fix;
                            state_q <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done      = rst & (state_q == DONE) & ~flush;
    assign stall_req = rst & (((state_q == IDLE) & start & ~flush) | (state_q == CALC));
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: the stimulus side queues hand-computed results,
// and a monitor pops and checks them (value and cycle) whenever done pulses.
module tb_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         stall_req, done;
    logic [W-1:0] hi_out, lo_out;

    divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .flush     (flush),
        .dividend  (dividend),
        .divisor   (divisor),
        .stall_req (stall_req),
        .done      (done),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        int           due;
        string        name;
    } exp_t;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail = 0;
    logic [W-1:0] last_lo = '0;
    logic [W-1:0] last_hi = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: samples 2 ns after the falling edge, well away from the rising edge.
    always begin : monitor
        exp_t e;
        @(negedge clk);
        #2;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_lo"}, lo_out, e.lo);
                check({e.name, "_hi"}, hi_out, e.hi);
                check({e.name, "_cycle"}, W'(cyc), W'(e.due));
            end
        end
    end

    // Drives a request in the current cycle (cycle 0) and checks stall_req there.
    task automatic issue(input string name, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] elo,
                         input logic [W-1:0] ehi, input bit push);
        exp_t e;
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        flush     = 1'b0;
        if (push) begin
            e.lo   = elo;
            e.hi   = ehi;
            e.due  = cyc + ((b == '0) ? 1 : W + 1);
            e.name = name;
            sb.push_back(e);
            last_lo = elo;
            last_hi = ehi;
        end
        #1 check({name, "_stall_c0"}, W'(stall_req), W'(1));
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Full divide; start stays high with junk operands during CALC/DONE to show it is ignored.
    task automatic run(input string name, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] elo, input logic [W-1:0] ehi);
        int last;
        issue(name, sgn, a, b, elo, ehi, 1'b1);
        last = (b == '0) ? 1 : W + 1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            start     = 1'b1;
            is_signed = ~sgn;
            dividend  = $urandom;
            divisor   = $urandom | 32'h1;
            #1 check($sformatf("%s_stall_c%0d", name, c), W'(stall_req), W'(c < last));
        end
        @(negedge clk);
        start = 1'b0;
        drain(name);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with start asserted: outputs must be gated low.
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        repeat (2) @(negedge clk);
        #1;
        check("rst_done", W'(done), W'(0));
        check("rst_stall", W'(stall_req), W'(0));
        check("rst_lo", lo_out, '0);
        check("rst_hi", hi_out, '0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run("divu_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1);
        run("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
        run("divu_5_9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5);

        // start together with flush in IDLE must be refused.
        @(negedge clk);
        start    = 1'b1;
        flush    = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd1;
        #1 check("idle_flush_stall", W'(stall_req), W'(0));
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1 check("idle_flush_stall_next", W'(stall_req), W'(0));
        repeat (5) @(negedge clk);

        // Flush in cycle 10 of DIVU 100/7: no done, previous result kept.
        issue("flush_divu", 1'b0, 32'd100, 32'd7, '0, '0, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 10) flush = 1'b1;
            else #1 check($sformatf("flush_stall_c%0d", c), W'(stall_req), W'(1));
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_stall_c11", W'(stall_req), W'(0));
        check("flush_keep_lo", lo_out, last_lo);
        check("flush_keep_hi", hi_out, last_hi);
        repeat (40) @(negedge clk);
        check("flush_idle_stall", W'(stall_req), W'(0));
        run("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        run("div_by0_s", 1'b1, 32'h0000_1234, 32'd0, 32'd0, 32'd0);
        run("divu_100_7_b", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run("divu_by0_u", 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);

        // Reset in cycle 15 of a divide.
        run("divu_100_7_c", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        issue("rst_mid", 1'b0, 32'd100, 32'd7, '0, '0, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("rst_mid_done", W'(done), W'(0));
        check("rst_mid_stall", W'(stall_req), W'(0));
        @(negedge clk);
        #1;
        check("rst_mid_lo", lo_out, '0);
        check("rst_mid_hi", hi_out, '0);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_lo", lo_out, '0);
        run("post_rst_div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

        repeat (3) @(negedge clk);
        drain("final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-low.
REQ-004 Port: start  input  1  divide request; sampled only in IDLE.
REQ-005 Port: is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-006 Port: flush  input  1  pipeline cancel; aborts any operation in progress.
REQ-007 Port: dividend  input  WIDTH  numerator; sampled with start.
REQ-008 Port: divisor  input  WIDTH  denominator; sampled with start.
REQ-009 Port: stall_req  output  1  pipeline hold request, combinational.
REQ-010 Port: done  output  1  one-cycle result-valid pulse; drives the HI/LO register write enable.
REQ-011 Port: hi_out  output  WIDTH  remainder; drives HI write data.
REQ-012 Port: lo_out  output  WIDTH  quotient; drives LO write data.

Function
REQ-013 The block SHALL implement FSM states IDLE, CALC and DONE.
REQ-014 IDLE: start=1 and flush=0 with divisor!=0 SHALL latch the operands and move to CALC, with the step counter set to 0.
REQ-015 IDLE: start=1 and flush=0 with divisor==0 SHALL move directly to DONE, with hi_out and lo_out loaded with 0.
REQ-016 IDLE with start=0, or with start=1 and flush=1, SHALL stay in IDLE and latch nothing.
REQ-017 CALC SHALL perform one restoring shift-subtract step per cycle on unsigned magnitudes, for exactly WIDTH steps.
REQ-018 The last CALC step SHALL register the sign-corrected quotient into lo_out and remainder into hi_out, then move to DONE.
REQ-019 Signed mode: magnitudes are |dividend| and |divisor|; quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend).
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo_out=0x80000000 and hi_out=0 (wrap, no trap).
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-022 done SHALL equal (state==DONE) AND NOT flush.
REQ-023 Latency: with start high in cycle 0, done SHALL be high in cycle WIDTH+1 (33) for divisor!=0, and in cycle 1 for divisor==0.
REQ-024 stall_req SHALL equal (IDLE AND start AND NOT flush) OR (state==CALC); it SHALL be low in DONE.
REQ-025 start SHALL be ignored in CALC and DONE; a new request is accepted only in IDLE, no earlier than the cycle after DONE.
REQ-026 flush=1 in CALC or DONE SHALL force IDLE at the next edge, with no done pulse, and SHALL leave hi_out/lo_out unchanged.
REQ-027 hi_out and lo_out SHALL hold the last completed result until the next completion; operand input changes during CALC SHALL have no effect.

Reset
REQ-028 rst=0 at a rising edge SHALL force IDLE, counter=0, hi_out=0 and lo_out=0, from any state including mid-CALC.
REQ-029 While rst=0, done and stall_req SHALL be 0.
REQ-030 The first start after rst returns high SHALL be processed normally.

Verification
REQ-031 DIVU 100/7, start in cycle 0 -> done=1 only in cycle 33, lo_out=14, hi_out=2, stall_req high cycles 0-32.
REQ-032 DIV 0xFFFFFFF9 (-7) / 2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF; DIV 7 / 0xFFFFFFFE -> lo_out=0xFFFFFFFD, hi_out=1.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0; DIVU 0xFFFFFFFF/1 -> lo_out=0xFFFFFFFF, hi_out=0.
REQ-034 Divisor 0, any mode -> done in cycle 1, hi_out=lo_out=0, stall_req high only in cycle 0.
REQ-035 flush in cycle 10 of DIVU 100/7 -> no done, stall_req low from cycle 11, outputs keep prior values; a new DIVU 9/3 gives lo_out=3, hi_out=0.
REQ-036 rst=0 in cycle 15 of a divide -> IDLE, outputs 0, no done; a new start after reset completes with the correct result.
